ring_drain: RTL and testbench

RING_DRAIN -- requirements
Module: ring_drain

---
 rtl/ring_drain.sv | 148 ++++++++++++++
 tb/tb_ring_drain.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ring_drain.sv
// ring_drain: drains a multi-lane ring-buffer read port into a single
// valid/ready output stream.
//
// Each batch is a contiguous prefix of valid lanes, taken from lane 0 up to
// the first invalid lane. The batch is captured into a small staging array
// and presented one entry per cycle. The next batch is loaded in the same
// cycle that the last staged entry pops, so the stream has no bubbles.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears all state and forces outputs to 0
//   flush_     active-low; drops staged entries and blocks loading
//   rd         per-lane read data (READ x DATA)
//   ridx       per-lane ring index (READ x ADDR)
//   rv         per-lane valid, ACT polarity
//   re         per-lane consume, ACT polarity, combinational
//   out_valid  a staged entry is present
//   out_ready  downstream accepts the head entry
//   out_data   head entry data
//   out_idx    head entry ring index
//   out_last   head entry is the final staged entry of the batch
module ring_drain #(
    parameter int unsigned DATA = 64,
    parameter int unsigned READ = 4,
    parameter int unsigned ADDR = 4,
    parameter bit          ACT  = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_,
    input  logic [READ-1:0][DATA-1:0]  rd,
    input  logic [READ-1:0][ADDR-1:0]  ridx,
    input  logic [READ-1:0]            rv,
    output logic [READ-1:0]            re,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA-1:0]            out_data,
    output logic [ADDR-1:0]            out_idx,
    output logic                       out_last
);

    localparam bit ENABLE  = ACT ? 1'b1 : 1'b0;
    localparam bit DISABLE = ~ENABLE;

    // cnt spans 0..READ; ptr spans 0..READ-1
    localparam int unsigned CW = $clog2(READ + 1);
    localparam int unsigned PW = (READ > 1) ? $clog2(READ) : 1;

    typedef struct packed {
        logic [DATA-1:0] data;
        logic [ADDR-1:0] idx;
    } entry_t;

    entry_t          slot [READ];
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_d;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_d;
    logic [CW-1:0]   avail;
    logic            staged;
    logic            tail;
    logic            pop;
    logic            load;

    // Count the leading valid lanes; the first invalid lane ends the run.
    always_comb begin
        logic run;
        avail = '0;
        run   = 1'b1;
        for (int i = 0; i < READ; i++) begin
            if (run && (rv[i] == ENABLE)) begin
                avail = avail + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // Head/tail status and handshake qualifiers.
    always_comb begin
        staged = (cnt != '0);
        // The head is the last staged entry when exactly one remains (cnt - ptr == 1).
        tail   = staged && ((CW'(ptr) + CW'(1)) == cnt);
        pop    = out_valid && out_ready;
        // A new batch may land only when staging is empty or about to become empty.
        load   = !reset && flush_ && (!staged || (tail && pop)) && (avail != '0);
    end

    // Lane consume: a contiguous prefix of the valid run, only on load.
    always_comb begin
        re = {READ{DISABLE}};
        for (int i = 0; i < READ; i++) begin
            if (load && (CW'(i) < avail)) begin
                re[i] = ENABLE;
            end
        end
    end

    // Next-state for the staging count and read pointer.
    always_comb begin
        cnt_d = cnt;
        ptr_d = ptr;
        if (!flush_) begin
            cnt_d = '0;
            ptr_d = '0;
        end else if (load) begin
            cnt_d = avail;
            ptr_d = '0;
        end else if (pop) begin
            if (tail) begin
                cnt_d = '0;
                ptr_d = '0;
            end else begin
                ptr_d = ptr + PW'(1);
            end
        end
    end

    // Staging state; reset wipes the slots as well so nothing stale can reappear.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            ptr <= '0;
            for (int i = 0; i < READ; i++) begin
                slot[i] <= '0;
            end
        end else begin
            cnt <= cnt_d;
            ptr <= ptr_d;
            if (load) begin
                for (int i = 0; i < READ; i++) begin
                    if (CW'(i) < avail) begin
                        slot[i] <= '{data: rd[i], idx: ridx[i]};
                    end
                end
            end
        end
    end

    // Output view of the head entry, forced to zero while reset is held.
    always_comb begin
        out_valid = !reset && staged;
        out_last  = out_valid && tail;
        out_data  = reset ? '0 : slot[ptr].data;
        out_idx   = reset ? '0 : slot[ptr].idx;
    end

endmodule

// File: tb/tb_ring_drain.sv
// Self-checking bench for ring_drain (ACT = Low): directed scenarios followed
// by a randomized run, all checked against a queue-based reference model.
module tb_ring_drain;

    localparam int unsigned DATA = 64;
    localparam int unsigned READ = 4;
    localparam int unsigned ADDR = 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      flush_;
    logic [READ-1:0][DATA-1:0] rd;
    logic [READ-1:0][ADDR-1:0] ridx;
    logic [READ-1:0]           rv;
    logic [READ-1:0]           re;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA-1:0]           out_data;
    logic [ADDR-1:0]           out_idx;
    logic                      out_last;

    always #5 clk = ~clk;

    ring_drain #(.DATA(DATA), .READ(READ), .ADDR(ADDR), .ACT(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush_    (flush_),
        .rd        (rd),
        .ridx      (ridx),
        .rv        (rv),
        .re        (re),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    // Reference model: the staged entries still to be delivered, head first.
    typedef struct {
        logic [DATA-1:0] d;
        logic [ADDR-1:0] i;
    } ent_t;
    ent_t q[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic rand_data();
        for (int k = 0; k < READ; k++) begin
            rd[k] = {$urandom, $urandom};
        end
    endtask

    // One clock cycle: check outputs against the model, then advance the model.
    // Called at posedge+1 with inputs already driven.
    task automatic step();
        int              av;
        bit              run;
        bit              pop;
        bit              load;
        logic [READ-1:0] exp_re;
        #1;
        av  = 0;
        run = 1'b1;
        for (int k = 0; k < READ; k++) begin
            if (run && rv[k] == 1'b0) av++;
            else run = 1'b0;
        end
        pop    = !reset && (q.size() > 0) && out_ready;
        load   = !reset && flush_ && ((q.size() == 0) || (q.size() == 1 && pop)) && (av > 0);
        exp_re = '1;
        if (load) begin
            for (int k = 0; k < av; k++) exp_re[k] = 1'b0;
        end
        chk("re", 64'(re), 64'(exp_re));
        if (reset) begin
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_data",  out_data,       64'd0);
            chk("rst_idx",   64'(out_idx),   64'd0);
            chk("rst_last",  64'(out_last),  64'd0);
        end else begin
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            if (q.size() > 0) begin
                chk("out_data", out_data,      q[0].d);
                chk("out_idx",  64'(out_idx),  64'(q[0].i));
                chk("out_last", 64'(out_last), 64'(q.size() == 1));
            end else begin
                chk("idle_last", 64'(out_last), 64'd0);
            end
        end
        @(posedge clk);
        if (reset || !flush_) begin
            q.delete();
        end else if (load) begin
            q.delete();
            for (int k = 0; k < av; k++) q.push_back('{rd[k], ridx[k]});
        end else if (pop) begin
            void'(q.pop_front());
        end
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        flush_    = 1'b1;
        out_ready = 1'b1;
        rv        = 4'b0000;
        rand_data();
        for (int k = 0; k < READ; k++) ridx[k] = ADDR'(k);

        // Reset held with all lanes valid: outputs zero, no consume.
        step();
        step();
        reset = 1'b0;
        rv    = 4'b1111;
        step();

        // Full batch 5,6,7,8 drained back to back.
        rv = 4'b0000;
        rand_data();
        for (int k = 0; k < READ; k++) ridx[k] = ADDR'(5 + k);
        step();
        rv = 4'b1111;
        for (int k = 0; k < READ; k++) begin
            chk("batch_idx", 64'(out_idx), 64'(5 + k));
            step();
        end

        // Gap at lane 1: only lane 0 is taken.
        rv = 4'b1010;
        rand_data();
        step();
        rv = 4'b1111;
        step();
        step();

        // Backpressure with two staged entries.
        rv = 4'b1100;
        rand_data();
        step();
        rv        = 4'b0000;
        out_ready = 1'b0;
        rand_data();
        repeat (3) step();
        out_ready = 1'b1;
        rv        = 4'b1111;
        repeat (3) step();

        // Continuous input with wrapping indices.
        rv = 4'b0000;
        for (int k = 0; k < READ; k++) ridx[k] = ADDR'(14 + k);
        repeat (12) begin
            rand_data();
            step();
        end
        rv = 4'b1111;
        repeat (4) step();

        // Flush at ptr = 1.
        rv = 4'b0000;
        rand_data();
        step();
        rv = 4'b1111;
        step();
        rv     = 4'b0000;
        flush_ = 1'b0;
        step();
        flush_ = 1'b1;
        rv     = 4'b1111;
        step();

        // Reset mid-batch, then resume loading.
        rv = 4'b0000;
        rand_data();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        rv    = 4'b1111;
        chk("post_rst_data", out_data,     64'd0);
        chk("post_rst_idx",  64'(out_idx), 64'd0);
        step();
        rv = 4'b0000;
        rand_data();
        step();
        repeat (4) step();

        // Randomized traffic.
        repeat (400) begin
            rv        = READ'($urandom);
            if ($urandom_range(0, 2) == 0) rv = 4'b0000;
            out_ready = ($urandom_range(0, 3) != 0);
            flush_    = ($urandom_range(0, 19) != 0);
            reset     = ($urandom_range(0, 99) == 0);
            rand_data();
            for (int k = 0; k < READ; k++) ridx[k] = ADDR'($urandom);
            step();
        end
        reset  = 1'b0;
        flush_ = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
